// File: rtl/regfile_wb_pkg.sv
// Shared types and sizing helpers for the register-file writeback arbiter and its producers.
package regfile_wb_pkg;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned rf_width_lp      = 32;
  localparam int unsigned rf_els_lp        = 32;
  localparam int unsigned rf_addr_width_lp = safe_clog2(rf_els_lp);

  typedef struct packed {
    logic [rf_addr_width_lp-1:0] addr;
    logic [rf_width_lp-1:0]      data;
  } regfile_wb_req_s;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Two-entry valid/ready buffer with registered ready; enqueue and dequeue may coincide.
module regfile_wb_fifo #(
  parameter type el_t = logic
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic v_i,
  input  el_t  data_i,
  output logic ready_o,
  output logic v_o,
  output el_t  data_o,
  input  logic yumi_i
);

  el_t        mem_q [2];
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, wr_ptr_q, ready_q;
  logic       enq;

  always_comb begin
    enq     = v_i & ready_q;
    count_d = count_q;
    case ({enq, yumi_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Ready is recomputed from next occupancy so it never sees the producer's valid combinationally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      if (enq)    wr_ptr_q <= ~wr_ptr_q;
      if (yumi_i) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

  assign ready_o = ready_q;
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Collects writebacks from several producers and packs up to num_ws_p of them per cycle onto
// the register file write ports, round-robin, never writing one address twice in a cycle.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int unsigned width_p           = rf_width_lp,
  parameter int unsigned els_p             = rf_els_lp,
  parameter int unsigned num_src_p         = 3,
  parameter int unsigned num_ws_p          = 2,
  parameter int unsigned x0_tied_to_zero_p = 1,
  localparam int unsigned addr_width_lp    = safe_clog2(els_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_src_p-1:0]               src_v_i,
  input  logic [num_src_p*addr_width_lp-1:0] src_addr_i,
  input  logic [num_src_p*width_p-1:0]       src_data_i,
  output logic [num_src_p-1:0]               src_ready_o,
  output logic [num_ws_p-1:0]                w_v_o,
  output logic [num_ws_p*addr_width_lp-1:0]  w_addr_o,
  output logic [num_ws_p*width_p-1:0]        w_data_o,
  output logic                               idle_o
);

  localparam int unsigned src_idx_w_lp = safe_clog2(num_src_p);

  typedef struct packed {
    logic [addr_width_lp-1:0] addr;
    logic [width_p-1:0]       data;
  } req_s;

  req_s                     head [num_src_p];
  logic [num_src_p-1:0]     head_v, fifo_ready, deq;
  logic [src_idx_w_lp-1:0]  rr_ptr_q, rr_ptr_d;
  logic [num_ws_p-1:0]      w_v;
  logic [addr_width_lp-1:0] w_addr [num_ws_p];
  logic [width_p-1:0]       w_data [num_ws_p];

  for (genvar s = 0; s < num_src_p; s++) begin : g_src
    req_s enq_req;
    assign enq_req = '{addr: src_addr_i[s*addr_width_lp +: addr_width_lp],
                       data: src_data_i[s*width_p +: width_p]};

    regfile_wb_fifo #(.el_t(req_s)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (src_v_i[s]),
      .data_i  (enq_req),
      .ready_o (fifo_ready[s]),
      .v_o     (head_v[s]),
      .data_o  (head[s]),
      .yumi_i  (deq[s])
    );
  end

  logic [src_idx_w_lp:0]   scan;
  logic [src_idx_w_lp-1:0] idx, last_idx;
  logic                    any_deq, conflict, placed, is_x0;

  // Scan from rr_ptr_q; x0 heads are dropped for free, others take the next free port.
  always_comb begin
    deq      = '0;
    w_v      = '0;
    scan     = '0;
    idx      = '0;
    last_idx = rr_ptr_q;
    any_deq  = 1'b0;
    conflict = 1'b0;
    placed   = 1'b0;
    is_x0    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned j = 0; j < num_ws_p; j++) begin
      w_addr[j] = '0;
      w_data[j] = '0;
    end
    for (int unsigned i = 0; i < num_src_p; i++) begin
      scan = (src_idx_w_lp+1)'(rr_ptr_q) + (src_idx_w_lp+1)'(i);
      if (scan >= (src_idx_w_lp+1)'(num_src_p)) scan = scan - (src_idx_w_lp+1)'(num_src_p);
      idx      = scan[src_idx_w_lp-1:0];
      is_x0    = (x0_tied_to_zero_p != 0) && (head[idx].addr == '0);
      conflict = 1'b0;
      placed   = 1'b0;
      for (int unsigned j = 0; j < num_ws_p; j++) begin
        if (w_v[j] && (w_addr[j] == head[idx].addr)) conflict = 1'b1;
      end
      if (head_v[idx]) begin
        if (is_x0) begin
          placed = 1'b1;
        end else if (!conflict) begin
          for (int unsigned j = 0; j < num_ws_p; j++) begin
            if (!placed && !w_v[j]) begin
              w_v[j]    = 1'b1;
              w_addr[j] = head[idx].addr;
              w_data[j] = head[idx].data;
              placed    = 1'b1;
            end
          end
        end
      end
      if (placed) begin
        deq[idx] = 1'b1;
        any_deq  = 1'b1;
        last_idx = idx;
      end
    end
    if (any_deq) begin
      rr_ptr_d = (last_idx == src_idx_w_lp'(num_src_p - 1)) ? '0
                                                            : last_idx + src_idx_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  for (genvar j = 0; j < num_ws_p; j++) begin : g_port
    assign w_addr_o[j*addr_width_lp +: addr_width_lp] = w_addr[j];
    assign w_data_o[j*width_p +: width_p]             = w_data[j];
  end

  assign w_v_o       = w_v;
  assign src_ready_o = fifo_ready;
  assign idle_o      = ~|head_v;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table plus a streaming scoreboard sequence for regfile_wb_arbiter (3 src, 2 ports).
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [2:0]  src_v_i;
  logic [14:0] src_addr_i;
  logic [95:0] src_data_i;
  logic [2:0]  src_ready_o;
  logic [1:0]  w_v_o;
  logic [9:0]  w_addr_o;
  logic [63:0] w_data_o;
  logic        idle_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter #(
    .width_p(32), .els_p(32), .num_src_p(3), .num_ws_p(2), .x0_tied_to_zero_p(1)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .src_v_i     (src_v_i),
    .src_addr_i  (src_addr_i),
    .src_data_i  (src_data_i),
    .src_ready_o (src_ready_o),
    .w_v_o       (w_v_o),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o),
    .idle_o      (idle_o)
  );

  typedef struct {
    logic [2:0]  v;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  e_ready;
    logic [1:0]  e_wv;
    logic [4:0]  e_a0, e_a1;
    logic [31:0] e_d0, e_d1;
    logic        e_idle;
    logic [1:0]  e_rr;
  } vec_t;

  vec_t vecs [14];

  int  acc [3];
  int  iss [3];
  logic [2:0] fire;
  logic saw_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [4:0] exp_addr(input int s, input int n);
    return (s == 2) ? 5'(20 + n) : 5'(8 + (n % 4));
  endfunction

  // Every port shown valid is dequeued at the next edge, so each sample sees each issue once.
  task automatic sb_sample();
    logic [4:0]  a;
    logic [31:0] d;
    int          s;
    for (int p = 0; p < 2; p++) begin
      if (w_v_o[p]) begin
        a = w_addr_o[p*5 +: 5];
        d = w_data_o[p*32 +: 32];
        s = int'(d[31:24]);
        if (s < 3) begin
          check($sformatf("sb_seq_src%0d", s), 32'(d[23:0]), 32'(iss[s]));
          check($sformatf("sb_addr_src%0d", s), 32'(a), 32'(exp_addr(s, iss[s])));
          iss[s]++;
        end else begin
          check("sb_src_id", 32'(s), 32'd0);
        end
      end
    end
    if (w_v_o == 2'b11) check("sb_same_addr", 32'(w_addr_o[4:0] != w_addr_o[9:5]), 32'd1);
  endtask

  initial begin
    //            v       a0    a1    a2    d0         d1         d2         rdy     wv     ea0   ea1   ed0        ed1        idle  rr
    vecs[0]  = '{3'b010, 5'd0, 5'd5, 5'd0, 32'h0,     32'hDEAD,  32'h0,     3'b111, 2'b01, 5'd5, 5'd0, 32'hDEAD,  32'h0,     1'b0, 2'd0};
    vecs[1]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     3'b111, 2'b00, 5'd0, 5'd0, 32'h0,     32'h0,     1'b1, 2'd2};
    vecs[2]  = '{3'b100, 5'd0, 5'd0, 5'd9, 32'h0,     32'h0,     32'h99,    3'b111, 2'b01, 5'd9, 5'd0, 32'h99,    32'h0,     1'b0, 2'd2};
    vecs[3]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     3'b111, 2'b00, 5'd0, 5'd0, 32'h0,     32'h0,     1'b1, 2'd0};
    vecs[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11,    32'h22,    32'h33,    3'b111, 2'b11, 5'd1, 5'd2, 32'h11,    32'h22,    1'b0, 2'd0};
    vecs[5]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     3'b111, 2'b01, 5'd3, 5'd0, 32'h33,    32'h0,     1'b0, 2'd2};
    vecs[6]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     3'b111, 2'b00, 5'd0, 5'd0, 32'h0,     32'h0,     1'b1, 2'd0};
    vecs[7]  = '{3'b011, 5'd7, 5'd7, 5'd0, 32'h1,     32'h2,     32'h0,     3'b111, 2'b01, 5'd7, 5'd0, 32'h1,     32'h0,     1'b0, 2'd0};
    vecs[8]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     3'b111, 2'b01, 5'd7, 5'd0, 32'h2,     32'h0,     1'b0, 2'd1};
    vecs[9]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     3'b111, 2'b00, 5'd0, 5'd0, 32'h0,     32'h0,     1'b1, 2'd2};
    vecs[10] = '{3'b100, 5'd0, 5'd0, 5'd10, 32'h0,    32'h0,     32'hA,     3'b111, 2'b01, 5'd10, 5'd0, 32'hA,    32'h0,     1'b0, 2'd2};
    vecs[11] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     3'b111, 2'b00, 5'd0, 5'd0, 32'h0,     32'h0,     1'b1, 2'd0};
    vecs[12] = '{3'b111, 5'd0, 5'd4, 5'd6, 32'hBAD,   32'h44,    32'h66,    3'b111, 2'b11, 5'd4, 5'd6, 32'h44,    32'h66,    1'b0, 2'd0};
    vecs[13] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0,     32'h0,     32'h0,     3'b111, 2'b00, 5'd0, 5'd0, 32'h0,     32'h0,     1'b1, 2'd0};

    reset_i    = 1'b1;
    src_v_i    = 3'b111;
    src_addr_i = {5'd3, 5'd2, 5'd1};
    src_data_i = {32'h3, 32'h2, 32'h1};

    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("rst%0d_ready", c), 32'(src_ready_o), 32'd0);
      check($sformatf("rst%0d_wv", c), 32'(w_v_o), 32'd0);
      check($sformatf("rst%0d_idle", c), 32'(idle_o), 32'd1);
    end
    reset_i = 1'b0;
    src_v_i = 3'b000;
    tick();
    check("post_rst_ready", 32'(src_ready_o), 32'h7);
    check("post_rst_idle", 32'(idle_o), 32'd1);
    check("post_rst_wv", 32'(w_v_o), 32'd0);

    for (int i = 0; i < 14; i++) begin
      src_v_i    = vecs[i].v;
      src_addr_i = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      src_data_i = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      tick();
      check($sformatf("v%0d_ready", i), 32'(src_ready_o), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_wv", i), 32'(w_v_o), 32'(vecs[i].e_wv));
      check($sformatf("v%0d_idle", i), 32'(idle_o), 32'(vecs[i].e_idle));
      check($sformatf("v%0d_rr", i), 32'(dut.rr_ptr_q), 32'(vecs[i].e_rr));
      if (vecs[i].e_wv[0]) begin
        check($sformatf("v%0d_addr0", i), 32'(w_addr_o[4:0]), 32'(vecs[i].e_a0));
        check($sformatf("v%0d_data0", i), w_data_o[31:0], vecs[i].e_d0);
      end
      if (vecs[i].e_wv[1]) begin
        check($sformatf("v%0d_addr1", i), 32'(w_addr_o[9:5]), 32'(vecs[i].e_a1));
        check($sformatf("v%0d_data1", i), w_data_o[63:32], vecs[i].e_d1);
      end
    end

    // Streaming: src0/src1 saturate both ports (colliding addresses), src2 pushes 4 requests.
    for (int s = 0; s < 3; s++) begin
      acc[s] = 0;
      iss[s] = 0;
    end
    saw_drop = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      src_v_i = {(acc[2] < 4), 1'b1, 1'b1};
      for (int s = 0; s < 3; s++) begin
        src_addr_i[s*5 +: 5]   = exp_addr(s, acc[s]);
        src_data_i[s*32 +: 32] = {8'(s), 24'(acc[s])};
      end
      fire = src_v_i & src_ready_o;
      if (!src_ready_o[2]) saw_drop = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) if (fire[s]) acc[s]++;
      sb_sample();
    end
    src_v_i = 3'b000;
    for (int cyc = 0; cyc < 30 && !idle_o; cyc++) begin
      tick();
      sb_sample();
    end
    check("stream_src2_ready_drop", 32'(saw_drop), 32'd1);
    check("stream_src2_accepted", 32'(acc[2]), 32'd4);
    check("stream_drained_idle", 32'(idle_o), 32'd1);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("stream_issued_src%0d", s), 32'(iss[s]), 32'(acc[s]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
